win_check_seq: RTL

WIN_CHECK_SEQ -- requirements
Module: win_check_seq

---
 rtl/board_pkg.sv | 22 ++
 rtl/win_check_seq_if.sv | 24 ++
 rtl/board_addr.sv | 36 +++
 rtl/win_check_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, cell codes and checker state encoding.
package board_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_RD,
    SCAN_EV,
    FULL_RD,
    FULL_EV,
    DONE
  } state_t;

  function automatic logic player_valid(input logic [1:0] p);
    return (p == P1) || (p == P2);
  endfunction
endpackage

// File: rtl/win_check_seq_if.sv
// Request/result handshake plus board read port of the win checker.
interface win_check_seq_if;
  logic       start;
  logic [2:0] row;
  logic [2:0] col;
  logic [1:0] player;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic       win;
  logic       full;

  modport slave (
    input  start, row, col, player, rd_data,
    output rd_en, rd_addr, busy, done, win, full
  );

  modport master (
    output start, row, col, player, rd_data,
    input  rd_en, rd_addr, busy, done, win, full
  );
endinterface

// File: rtl/board_addr.sv
// Combinational target-cell lookup: (row + k*dr, col + k*dc), bounds check and linear address.
module board_addr
  import board_pkg::*;
(
  input  logic [2:0]        i_row,
  input  logic [2:0]        i_col,
  input  logic [1:0]        i_dir,
  input  logic signed [3:0] i_k,
  output logic              o_in_bounds,
  output logic [5:0]        o_addr
);
  localparam logic signed [4:0] L_ROWS = 5'(ROWS);
  localparam logic signed [4:0] L_COLS = 5'(COLS);

  logic signed [4:0] w_k;
  logic signed [4:0] w_dr;
  logic signed [4:0] w_dc;
  logic signed [4:0] w_tr;
  logic signed [4:0] w_tc;

  always_comb begin
    w_k = {i_k[3], i_k};
    case (i_dir)
      2'd0:    begin w_dr = 5'sd0; w_dc = 5'sd1;  end
      2'd1:    begin w_dr = 5'sd1; w_dc = 5'sd0;  end
      2'd2:    begin w_dr = 5'sd1; w_dc = 5'sd1;  end
      default: begin w_dr = 5'sd1; w_dc = -5'sd1; end
    endcase
    w_tr = $signed({2'b00, i_row}) + w_k * w_dr;
    w_tc = $signed({2'b00, i_col}) + w_k * w_dc;
    o_in_bounds = (w_tr >= 5'sd0) && (w_tr < L_ROWS) &&
                  (w_tc >= 5'sd0) && (w_tc < L_COLS);
    // Only meaningful when in bounds; low bits are then the true coordinates.
    o_addr = 6'(w_tr[2:0]) * 6'd7 + 6'(w_tc[2:0]);
  end
endmodule

// File: rtl/win_check_seq.sv
// Sequential four-in-a-row checker around the last placed piece, plus top-row full detection.
module win_check_seq
  import board_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  win_check_seq_if.slave  bus
);
  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [1:0]        r_player;
  logic [1:0]        r_dir;
  logic signed [3:0] r_k;
  logic [2:0]        r_run;
  logic [2:0]        r_fcol;
  logic              r_win_acc;
  logic              r_full_acc;
  logic              r_win;
  logic              r_full;
  logic              r_done;

  logic              w_full_phase;
  logic [2:0]        w_sel_row;
  logic [2:0]        w_sel_col;
  logic [1:0]        w_sel_dir;
  logic signed [3:0] w_sel_k;
  logic              w_in_bounds;
  logic [5:0]        w_addr;
  logic              w_rd_en;
  logic              w_match;
  logic [2:0]        w_run_next;
  logic              w_last_k;
  logic              w_last_dir;
  logic              w_last_col;
  logic              w_args_ok;

  // The top-row sweep reuses the lookup with a fixed row 5 and zero offset.
  assign w_full_phase = (r_state == FULL_RD) || (r_state == FULL_EV);
  assign w_sel_row    = w_full_phase ? 3'd5   : r_row;
  assign w_sel_col    = w_full_phase ? r_fcol : r_col;
  assign w_sel_dir    = w_full_phase ? 2'd0   : r_dir;
  assign w_sel_k      = w_full_phase ? 4'sd0  : r_k;

  board_addr u_addr (
    .i_row       (w_sel_row),
    .i_col       (w_sel_col),
    .i_dir       (w_sel_dir),
    .i_k         (w_sel_k),
    .o_in_bounds (w_in_bounds),
    .o_addr      (w_addr)
  );

  assign w_match    = w_in_bounds && (bus.rd_data == r_player);
  assign w_run_next = !w_match ? 3'd0 : ((r_run == 3'd4) ? 3'd4 : r_run + 3'd1);
  assign w_last_k   = (r_k == 4'sd3);
  assign w_last_dir = (r_dir == 2'd3);
  assign w_last_col = (r_fcol == 3'd6);
  assign w_args_ok  = player_valid(r_player) && (r_row <= 3'd5) && (r_col <= 3'd6);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SCAN_RD;
      SCAN_RD: begin
        w_rd_en      = w_in_bounds;
        w_state_next = SCAN_EV;
      end
      SCAN_EV: w_state_next = (w_last_k && w_last_dir) ? FULL_RD : SCAN_RD;
      FULL_RD: begin
        w_rd_en      = 1'b1;
        w_state_next = FULL_EV;
      end
      FULL_EV: w_state_next = w_last_col ? DONE : FULL_RD;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_player   <= 2'd0;
      r_dir      <= 2'd0;
      r_k        <= 4'sd0;
      r_run      <= 3'd0;
      r_fcol     <= 3'd0;
      r_win_acc  <= 1'b0;
      r_full_acc <= 1'b0;
      r_win      <= 1'b0;
      r_full     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: if (bus.start) begin
          r_row      <= bus.row;
          r_col      <= bus.col;
          r_player   <= bus.player;
          r_dir      <= 2'd0;
          r_k        <= -4'sd3;
          r_run      <= 3'd0;
          r_win_acc  <= 1'b0;
          r_full_acc <= 1'b0;
          r_win      <= 1'b0;
          r_full     <= 1'b0;
        end
        SCAN_EV: begin
          if (w_run_next == 3'd4) r_win_acc <= 1'b1;
          if (w_last_k) begin
            r_k   <= -4'sd3;
            r_dir <= r_dir + 2'd1;
            r_run <= 3'd0;
            if (w_last_dir) begin
              r_fcol     <= 3'd0;
              r_full_acc <= 1'b1;
            end
          end else begin
            r_k   <= r_k + 4'sd1;
            r_run <= w_run_next;
          end
        end
        FULL_EV: begin
          if (bus.rd_data == EMPTY) r_full_acc <= 1'b0;
          r_fcol <= r_fcol + 3'd1;
          if (w_last_col) begin
            r_win  <= r_win_acc && w_args_ok;
            r_full <= r_full_acc && (bus.rd_data != EMPTY);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = w_addr;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.win     = r_win;
  assign bus.full    = r_full;
endmodule
